// File: rtl/obstacle_stream_sequencer_if.sv
// obstacle_stream_sequencer_if: vertex-memory read bus plus the valid/x/y/done stream toward the culling block
interface obstacle_stream_sequencer_if #(
  parameter int WORLD_BITS = 32,
  parameter int MEM_DEPTH = 1024
);
  logic [$clog2(MEM_DEPTH)-1:0] mem_addr_out;
  logic mem_rd_en_out;
  logic [2*WORLD_BITS-1:0] mem_data_in;
  logic valid_out;
  logic signed [WORLD_BITS-1:0] x_out;
  logic signed [WORLD_BITS-1:0] y_out;
  logic done_out;
  modport master (
    output mem_addr_out, mem_rd_en_out, valid_out, x_out, y_out, done_out,
    input mem_data_in
  );
  modport slave (
    input mem_addr_out, mem_rd_en_out, valid_out, x_out, y_out, done_out,
    output mem_data_in
  );
endinterface

// File: rtl/obstacle_stream_sequencer.sv
// obstacle_stream_sequencer: walks the obstacle list in vertex memory and streams each polygon as a valid/x/y burst.
// Defining OBSTACLE_SEQ_PERF_EN adds the frame_cycles_out/polygons_out counters.
module obstacle_stream_sequencer #(
  parameter int WORLD_BITS = 32,
  parameter int MAX_NUM_VERTICES = 8,
  parameter int MEM_DEPTH = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic start_in,
  input  logic signed [WORLD_BITS-1:0] screen_min_x_in,
  input  logic signed [WORLD_BITS-1:0] screen_max_x_in,
  input  logic signed [WORLD_BITS-1:0] screen_min_y_in,
  input  logic signed [WORLD_BITS-1:0] screen_max_y_in,
  output logic signed [WORLD_BITS-1:0] screen_min_x_out,
  output logic signed [WORLD_BITS-1:0] screen_max_x_out,
  output logic signed [WORLD_BITS-1:0] screen_min_y_out,
  output logic signed [WORLD_BITS-1:0] screen_max_y_out,
  obstacle_stream_sequencer_if.master bus,
  output logic busy_out,
  output logic truncated_out
`ifdef OBSTACLE_SEQ_PERF_EN
  ,
  output logic [31:0] frame_cycles_out,
  output logic [15:0] polygons_out
`endif
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = AW + 17;
  localparam logic [PW-1:0] DEPTH = PW'(MEM_DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [15:0] MAXV = 16'(MAX_NUM_VERTICES);
  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, HDR, HWAIT, STREAM, FLUSH, DONE} state_t;
  state_t state, state_d;
  logic [PW-1:0] ptr, ptr_d, hdr_ptr, hdr_ptr_d;
  logic [15:0] n, n_d, cnt, cnt_d, hdr_n;
  logic [1:0] wcnt, wcnt_d;
  logic [READ_LATENCY-1:0] tag, tag_d;
  logic trunc_d, accept, vtx_rd, in_range;
  assign hdr_n = bus.mem_data_in[15:0];
  assign in_range = ptr < DEPTH;
  assign accept = state == IDLE && start_in;
  assign vtx_rd = state == STREAM && in_range;
  assign busy_out = state inside {HDR, HWAIT, STREAM, FLUSH};
  assign bus.done_out = state == DONE;
  assign bus.mem_addr_out = ptr[AW-1:0];
  assign bus.mem_rd_en_out = (state == HDR || state == STREAM) && in_range;
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    hdr_ptr_d = hdr_ptr;
    n_d = n;
    cnt_d = cnt;
    wcnt_d = wcnt;
    trunc_d = truncated_out;
    tag_d = tag << 1;
    tag_d[0] = vtx_rd;
    case (state)
      IDLE: if (start_in) begin
        state_d = HDR;
        ptr_d = '0;
        trunc_d = 1'b0;
      end
      HDR: begin
        state_d = in_range ? HWAIT : FLUSH;
        wcnt_d = '0;
      end
      HWAIT: if (wcnt != LAST_WAIT) wcnt_d = wcnt + 2'd1;
        else if (hdr_n == '0) state_d = FLUSH;
        else begin
          state_d = STREAM;
          n_d = hdr_n;
          cnt_d = hdr_n > MAXV ? MAXV : hdr_n;
          trunc_d = truncated_out | (hdr_n > MAXV);
          hdr_ptr_d = ptr;
          ptr_d = ptr + ONE;
        end
      // the skipped tail of a truncated polygon is stepped over via the full count N
      STREAM: if (!in_range) state_d = FLUSH;
        else if (cnt == 16'd1) begin
          state_d = HDR;
          ptr_d = hdr_ptr + ONE + PW'(n);
        end else begin
          ptr_d = ptr + ONE;
          cnt_d = cnt - 16'd1;
        end
      FLUSH: if (tag == '0 && !bus.valid_out) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      ptr <= '0;
      hdr_ptr <= '0;
      n <= '0;
      cnt <= '0;
      wcnt <= '0;
      tag <= '0;
      truncated_out <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.x_out <= '0;
      bus.y_out <= '0;
      screen_min_x_out <= '0;
      screen_max_x_out <= '0;
      screen_min_y_out <= '0;
      screen_max_y_out <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      hdr_ptr <= hdr_ptr_d;
      n <= n_d;
      cnt <= cnt_d;
      wcnt <= wcnt_d;
      tag <= tag_d;
      truncated_out <= trunc_d;
      bus.valid_out <= tag[READ_LATENCY-1];
      if (tag[READ_LATENCY-1]) begin
        bus.x_out <= bus.mem_data_in[WORLD_BITS-1:0];
        bus.y_out <= bus.mem_data_in[2*WORLD_BITS-1:WORLD_BITS];
      end
      if (accept) begin
        screen_min_x_out <= screen_min_x_in;
        screen_max_x_out <= screen_max_x_in;
        screen_min_y_out <= screen_min_y_in;
        screen_max_y_out <= screen_max_y_in;
      end
    end
`ifdef OBSTACLE_SEQ_PERF_EN
  logic [31:0] cyc;
  logic [15:0] polys;
  // cyc counts the accept cycle onward, so +2 at the FLUSH exit covers the done cycle too
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cyc <= '0;
      polys <= '0;
      frame_cycles_out <= '0;
      polygons_out <= '0;
    end else begin
      if (accept) cyc <= 32'd1;
      else if (busy_out) cyc <= cyc + 32'd1;
      if (accept) polys <= '0;
      else if (state == HWAIT && state_d == STREAM) polys <= polys + 16'd1;
      if (state == FLUSH && state_d == DONE) begin
        frame_cycles_out <= cyc + 32'd2;
        polygons_out <= polys;
      end
    end
`endif
endmodule

// File: tb/tb_obstacle_stream_sequencer.sv
// tb_obstacle_stream_sequencer: stimulus queues expected vertices, burst lengths and frame results; a negedge monitor checks them.
module tb_obstacle_stream_sequencer;
  localparam int WB = 32;
  localparam int MAXV = 8;
  localparam int DEPTH = 16;
  localparam int RL = 2;
  typedef struct packed {logic signed [31:0] y; logic signed [31:0] x;} vtx_t;
  typedef struct packed {logic tr; logic signed [31:0] x0; logic signed [31:0] x1; logic signed [31:0] y0; logic signed [31:0] y1;} frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [31:0] min_x = 0, max_x = 0, min_y = 0, max_y = 0;
  logic signed [31:0] o_min_x, o_max_x, o_min_y, o_max_y;
  logic busy, trunc;
`ifdef OBSTACLE_SEQ_PERF_EN
  logic [31:0] fc;
  logic [15:0] pc;
`endif
  logic [63:0] mem [DEPTH];
  logic [63:0] pipe [RL];
  vtx_t vq[$];
  int bq[$];
  frame_t dq[$];
  vtx_t ve;
  frame_t fr;
  int total = 0, bad = 0, dones = 0, run = 0, gap = 0, last_addr = -1;
  bit first = 1'b1;
  obstacle_stream_sequencer_if #(.WORLD_BITS(WB), .MEM_DEPTH(DEPTH)) bus();
  obstacle_stream_sequencer #(.WORLD_BITS(WB), .MAX_NUM_VERTICES(MAXV), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .start_in(start),
    .screen_min_x_in(min_x),
    .screen_max_x_in(max_x),
    .screen_min_y_in(min_y),
    .screen_max_y_in(max_y),
    .screen_min_x_out(o_min_x),
    .screen_max_x_out(o_max_x),
    .screen_min_y_out(o_min_y),
    .screen_max_y_out(o_max_y),
    .bus(bus),
    .busy_out(busy),
    .truncated_out(trunc)
`ifdef OBSTACLE_SEQ_PERF_EN
    ,
    .frame_cycles_out(fc),
    .polygons_out(pc)
`endif
  );
  always #5 clk = ~clk;
  assign bus.mem_data_in = pipe[RL-1];
  always @(posedge clk) begin
    pipe[0] <= bus.mem_rd_en_out ? mem[bus.mem_addr_out] : '0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  function automatic void chk(string name, logic signed [63:0] got, logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      gap = 0;
      first = 1'b1;
    end else begin
      if (bus.mem_rd_en_out) begin
        chk("addr_order", 64'(int'(bus.mem_addr_out) > last_addr), 1);
        last_addr = int'(bus.mem_addr_out);
      end
      if (bus.valid_out) begin
        if (run == 0 && !first) chk("burst_gap", 64'(gap >= RL + 1), 1);
        first = 1'b0;
        run++;
        chk("vertex_expected", 64'(vq.size() != 0), 1);
        if (vq.size() != 0) begin
          ve = vq.pop_front();
          chk("x", bus.x_out, ve.x);
          chk("y", bus.y_out, ve.y);
        end
      end else begin
        if (run != 0) begin
          chk("burst_expected", 64'(bq.size() != 0), 1);
          if (bq.size() != 0) chk("burst_len", run, bq.pop_front());
          run = 0;
          gap = 0;
        end
        gap++;
      end
      if (bus.done_out) begin
        dones++;
        first = 1'b1;
        chk("done_busy", busy, 0);
        chk("done_valid", bus.valid_out, 0);
        chk("done_vq_empty", vq.size(), 0);
        chk("done_bq_empty", bq.size(), 0);
        chk("done_expected", 64'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          fr = dq.pop_front();
          chk("truncated", trunc, fr.tr);
          chk("min_x", o_min_x, fr.x0);
          chk("max_x", o_max_x, fr.x1);
          chk("min_y", o_min_y, fr.y0);
          chk("max_y", o_max_y, fr.y1);
        end
      end
    end
  end
  function automatic void clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endfunction
  function automatic void hdr(int a, int n);
    mem[a] = 64'(n);
  endfunction
  function automatic void vtx(int a, int x, int y, bit exp);
    vtx_t v;
    v.x = x;
    v.y = y;
    mem[a] = v;
    if (exp) vq.push_back(v);
  endfunction
  function automatic void setup_single();
    clear_mem();
    hdr(0, 3);
    vtx(1, 1, 1, 1'b1);
    vtx(2, 2, 2, 1'b1);
    vtx(3, 3, 3, 1'b1);
    hdr(4, 0);
    bq.push_back(3);
  endfunction
  function automatic void setup_trunc();
    clear_mem();
    hdr(0, 10);
    for (int i = 1; i <= 10; i++) vtx(i, i * 10, -i, i <= MAXV);
    hdr(11, 1);
    vtx(12, 4, 4, 1'b1);
    hdr(13, 0);
    bq.push_back(8);
    bq.push_back(1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame(input int x0, input int x1, input int y0, input int y1, input bit tr);
    frame_t f;
    f.tr = tr;
    f.x0 = x0;
    f.x1 = x1;
    f.y0 = y0;
    f.y1 = y1;
    dq.push_back(f);
    last_addr = -1;
    min_x = x0;
    max_x = x1;
    min_y = y0;
    max_y = y1;
    start = 1'b1;
    tick();
    start = 1'b0;
    min_x = 777;
    max_x = -777;
    min_y = 555;
    max_y = -555;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic wait_done(input string name);
    int d0;
    d0 = dones;
    for (int i = 0; i < 400 && dones == d0; i++) tick();
    repeat (8) tick();
    chk(name, dones - d0, 1);
    chk("idle_busy", busy, 0);
  endtask
  task automatic wait_vq(input int n);
    for (int i = 0; i < 200 && vq.size() > n; i++) tick();
  endtask
  initial begin
    int d0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", bus.mem_rd_en_out, 0);
    chk("rst_addr", bus.mem_addr_out, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_x", bus.x_out, 0);
    chk("rst_min_x", o_min_x, 0);
    rst_n = 1'b1;
    tick();
    setup_single();
    start_frame(-100, 100, -50, 50, 1'b0);
    wait_done("frame1_done");
    clear_mem();
    hdr(0, 2);
    vtx(1, 5, 6, 1'b1);
    vtx(2, 7, 8, 1'b1);
    hdr(3, 1);
    vtx(4, 9, 9, 1'b1);
    hdr(5, 0);
    bq.push_back(2);
    bq.push_back(1);
    d0 = dones;
    start_frame(-200, 200, -150, 150, 1'b0);
    wait_vq(2);
    min_x = 1;
    max_x = 2;
    min_y = 3;
    max_y = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_mid_start", busy, 1);
    for (int i = 0; i < 400 && !bus.done_out; i++) tick();
    chk("frame2_done_seen", bus.done_out, 1);
    min_x = 9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_done_start", busy, 0);
    repeat (4) tick();
    chk("busy_stays_idle", busy, 0);
    chk("frame2_single_done", dones - d0, 1);
    chk("bounds_kept", o_min_x, -200);
    setup_trunc();
    start_frame(-10, 10, -20, 20, 1'b1);
    wait_done("frame3_done");
    setup_trunc();
    start_frame(-30, 30, -40, 40, 1'b1);
    wait_vq(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", bus.done_out, 0);
    chk("mid_rst_trunc", trunc, 0);
    chk("mid_rst_rd_en", bus.mem_rd_en_out, 0);
    chk("mid_rst_x", bus.x_out, 0);
    chk("mid_rst_min_x", o_min_x, 0);
    vq.delete();
    bq.delete();
    dq.delete();
    d0 = dones;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("no_done_after_rst", dones - d0, 0);
    setup_single();
    start_frame(-1, 1, -2, 2, 1'b0);
    wait_done("post_rst_done");
    clear_mem();
    for (int p = 0; p < 3; p++) begin
      hdr(4 * p, 3);
      for (int k = 1; k <= 3; k++) vtx(4 * p + k, 100 * p + k, k, 1'b1);
      bq.push_back(3);
    end
    hdr(12, 5);
    vtx(13, 301, 1, 1'b1);
    vtx(14, 302, 2, 1'b1);
    vtx(15, 303, 3, 1'b1);
    bq.push_back(3);
    start_frame(0, 640, 0, 480, 1'b0);
    wait_done("noterm_done");
    chk("last_addr", last_addr, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
